ioctl_loader_bridge: RTL

- Sits between the hps_io ioctl download stream and the PC88 core loader port (LOADER_ADR/WDAT/OE/WR/ACK/DONE).
- Replaces the ad-hoc single-register handshake at top level.
- Buffers incoming ROM bytes in a small FIFO and throttles hps_io through ioctl_wait.
- Replays each byte to the core with a req/ack handshake, then asserts a sticky done once the download has ended and everything has drained.

---
 rtl/ioctl_loader_bridge.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ioctl_loader_bridge.sv
// ioctl_loader_bridge: buffers hps_io ioctl download bytes in a small FIFO and
// replays them one at a time to the PC88 core loader port.
//
// Loader handshake: the bridge loads ldr_adr/ldr_wdat and raises ldr_wr in the
// same clock edge. ldr_adr and ldr_wdat hold steady for as long as ldr_wr is high.
// The core accepts the byte with a rising edge on ldr_ack. The bridge drops
// ldr_wr on the clock edge that sees that rising edge. The core may keep ldr_ack
// high afterwards, because only the 0->1 transition is counted. The bridge
// abandons a byte if no edge arrives within ACK_TIMEOUT cycles.
module ioctl_loader_bridge #(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         ADDR_W      = 19,
    parameter logic [7:0] LDR_INDEX   = 8'h00,
    parameter int         ACK_TIMEOUT = 65535
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] ldr_adr,
    output logic [7:0]        ldr_wdat,
    output logic              ldr_oe,
    output logic              ldr_wr,
    input  logic              ldr_ack,
    output logic              ldr_done,
    output logic [ADDR_W:0]   byte_count,
    output logic [2:0]        err_flags
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 8;
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_HIGH = LVL_W'(FIFO_DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic [LVL_W-1:0]   level_nxt;
    logic [ENT_W-1:0]   head;

    logic [TMR_W-1:0]   timer;
    logic               ack_d;
    logic               dl_d;
    logic               end_pend;

    logic               index_match;
    logic               accept;
    logic               in_range;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               ack_rise;
    logic               ack_ok;
    logic               tmo;

    assign index_match = (ioctl_index == LDR_INDEX);
    assign accept      = ioctl_download & ioctl_wr & index_match & ~ldr_done;
    assign in_range    = (ioctl_addr[24:ADDR_W] == '0);
    assign fifo_empty  = (level == '0);
    assign fifo_full   = (level == LVL_FULL);
    assign push        = accept & in_range & ~fifo_full;
    assign head        = fifo_mem[rd_ptr];
    assign ack_rise    = ldr_ack & ~ack_d;

    // FIFO occupancy after this cycle's push and pop; a simultaneous push and pop cancel
    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LVL_W'(1);
        end else if (!push && pop) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    // FIFO storage: payload only, so it needs no reset
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {ioctl_addr[ADDR_W-1:0], ioctl_dout};
        end
    end

    // FIFO pointers, level and registered backpressure (one slot kept for an in-flight write)
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            ioctl_wait <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level      <= level_nxt;
            ioctl_wait <= (level_nxt >= LVL_HIGH);
        end
    end

    // Output FSM state register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Output FSM next state: issue the FIFO head, then wait for an ack edge or the timeout
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        ack_ok    = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_rise) begin
                    ack_ok    = 1'b1;
                    state_nxt = IDLE;
                end else if (timer == TMR_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Loader port, ack timer, byte counter and sticky error flags
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ldr_adr    <= '0;
            ldr_wdat   <= '0;
            ldr_wr     <= 1'b0;
            timer      <= '0;
            ack_d      <= 1'b0;
            byte_count <= '0;
            err_flags  <= '0;
        end else begin
            ack_d <= ldr_ack;
            if (pop) begin
                ldr_adr  <= head[ENT_W-1:8];
                ldr_wdat <= head[7:0];
                ldr_wr   <= 1'b1;
                timer    <= '0;
            end else if (ack_ok || tmo) begin
                ldr_wr <= 1'b0;
            end else if (state == WAIT_ACK) begin
                timer <= timer + TMR_W'(1);
            end
            if (ack_ok && (byte_count != '1)) begin
                byte_count <= byte_count + (ADDR_W+1)'(1);
            end
            if (tmo)                               err_flags[2] <= 1'b1;
            if (accept && !in_range)               err_flags[1] <= 1'b1;
            if (accept && in_range && fifo_full)   err_flags[0] <= 1'b1;
        end
    end

    // Session tracking: end of download, sticky done once drained, loader enable
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_d     <= 1'b0;
            end_pend <= 1'b0;
            ldr_done <= 1'b0;
            ldr_oe   <= 1'b0;
        end else begin
            dl_d <= ioctl_download;
            if (dl_d && !ioctl_download && index_match) begin
                end_pend <= 1'b1;
            end
            if (end_pend && fifo_empty && !push && (state == IDLE) && !ldr_wr) begin
                ldr_done <= 1'b1;
            end
            ldr_oe <= ((ioctl_download & index_match) | end_pend | ~fifo_empty | ldr_wr)
                      & ~ldr_done;
        end
    end

endmodule
